// File: rtl/microcode_seq.sv
// Microcode sequencer: a writable control store and opcode dispatch table.
// Streams control words to the datapath with stall, wait-on-condition, halt and fault handling.
module microcode_seq #(
    parameter int CTRL_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 6,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = '1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    output logic [CTRL_WIDTH-3:0]   ctrl_o,
    output logic                    ctrl_valid_o,
    input  logic                    stall_i,
    input  logic                    cond_i,
    input  logic                    restart_i,
    output logic                    halted_o,
    output logic                    fault_o,
    output logic [1:0]              fault_cause_o,
    output logic [ADDR_WIDTH-1:0]   upc_o,
    input  logic                    wr_en_i,
    input  logic                    wr_sel_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [CTRL_WIDTH-1:0]   wr_data_i,
    output logic                    wr_ack_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NOPS  = 1 << OPCODE_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

    state_t                  state_q, state_d;
    logic [CTRL_WIDTH-3:0]   ctrl_q, ctrl_d;
    logic [ADDR_WIDTH-1:0]   upc_q, upc_d;
    logic                    eos_q, eos_d;
    logic                    wait_q, wait_d;
    logic [1:0]              cause_q, cause_d;
    logic                    wr_ack_q;
    logic [NOPS-1:0]         disp_vld_q, disp_vld_d;

    logic [CTRL_WIDTH-1:0]   store_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   disp_q  [NOPS];

    logic                    wr_do;
    logic                    advance;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   ld_addr;
    logic [CTRL_WIDTH-1:0]   ld_word;

    assign wr_do         = wr_en_i && (state_q != RUN);
    assign advance       = (state_q == RUN) && !stall_i && (!wait_q || cond_i);
    assign instr_ready_o = ((state_q == IDLE) && !wr_en_i) || ((state_q == RUN) && eos_q && advance);
    assign accept        = instr_valid_i && instr_ready_o;

    // One store read port serves both sequential fetch and dispatch; a dispatch only
    // happens on an EOS word (or from IDLE), so the two never compete.
    assign ld_addr = ((state_q == RUN) && !eos_q) ? upc_q + 1'b1 : disp_q[opcode_i];
    assign ld_word = store_q[ld_addr];

    always_ff @(posedge clk) begin
        if (wr_do && !wr_sel_i) begin
            store_q[wr_addr_i] <= wr_data_i;
        end
        if (wr_do && wr_sel_i) begin
            disp_q[wr_addr_i[OPCODE_WIDTH-1:0]] <= wr_data_i[ADDR_WIDTH-1:0];
        end
    end

    always_comb begin
        disp_vld_d = disp_vld_q;
        if (wr_do && wr_sel_i) begin
            disp_vld_d[wr_addr_i[OPCODE_WIDTH-1:0]] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        upc_d   = upc_q;
        eos_d   = eos_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        if (accept) begin
            ctrl_d = '0;
            upc_d  = '0;
            eos_d  = 1'b0;
            wait_d = 1'b0;
            if (opcode_i == HALT_OPCODE) begin
                state_d = HALT;
            end else if (!disp_vld_q[opcode_i]) begin
                state_d = FAULT;
                cause_d = 2'd1;
            end else begin
                state_d = RUN;
                ctrl_d  = ld_word[CTRL_WIDTH-1:2];
                wait_d  = ld_word[1];
                eos_d   = ld_word[0];
                upc_d   = disp_q[opcode_i];
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (advance) begin
                        if (eos_q || (upc_q == '1)) begin
                            state_d = eos_q ? IDLE : FAULT;
                            cause_d = eos_q ? 2'd0 : 2'd2;
                            ctrl_d  = '0;
                            upc_d   = '0;
                            eos_d   = 1'b0;
                            wait_d  = 1'b0;
                        end else begin
                            ctrl_d = ld_word[CTRL_WIDTH-1:2];
                            wait_d = ld_word[1];
                            eos_d  = ld_word[0];
                            upc_d  = ld_addr;
                        end
                    end
                end
                HALT, FAULT: begin
                    if (restart_i) begin
                        state_d = IDLE;
                        cause_d = 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            upc_q      <= '0;
            eos_q      <= 1'b0;
            wait_q     <= 1'b0;
            cause_q    <= 2'd0;
            wr_ack_q   <= 1'b0;
            disp_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            upc_q      <= upc_d;
            eos_q      <= eos_d;
            wait_q     <= wait_d;
            cause_q    <= cause_d;
            wr_ack_q   <= wr_do;
            disp_vld_q <= disp_vld_d;
        end
    end

    assign ctrl_o        = ctrl_q;
    assign ctrl_valid_o  = (state_q == RUN);
    assign halted_o      = (state_q == HALT);
    assign fault_o       = (state_q == FAULT);
    assign fault_cause_o = cause_q;
    assign upc_o         = upc_q;
    assign wr_ack_o      = wr_ack_q;

endmodule

// File: tb/tb_microcode_seq.sv
// Scoreboard bench for microcode_seq: stimulus pushes expected words, a negedge monitor
// compares every live control word and pops it when the datapath advances.
module tb_microcode_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [5:0]  opcode_i = '0;
    logic [29:0] ctrl_o;
    logic        ctrl_valid_o;
    logic        stall_i = 1'b0;
    logic        cond_i = 1'b0;
    logic        restart_i = 1'b0;
    logic        halted_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic [7:0]  upc_o;
    logic        wr_en_i = 1'b0;
    logic        wr_sel_i = 1'b0;
    logic [7:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        wr_ack_o;

    microcode_seq dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .opcode_i(opcode_i),
        .ctrl_o(ctrl_o), .ctrl_valid_o(ctrl_valid_o), .stall_i(stall_i), .cond_i(cond_i),
        .restart_i(restart_i), .halted_o(halted_o), .fault_o(fault_o),
        .fault_cause_o(fault_cause_o), .upc_o(upc_o),
        .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .wr_ack_o(wr_ack_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  upc;
        logic [29:0] ctrl;
        logic        wt;
    } exp_t;

    exp_t sb[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    localparam logic [29:0] A = 30'h0123_4567, B = 30'h2BCD_EF01, C = 30'h1111_2222;
    localparam logic [29:0] D = 30'h0333_4444, E = 30'h0555_6666, F = 30'h0777_8888;
    localparam logic [29:0] G = 30'h0999_AAAA, H = 30'h0BBB_CCCC, X = 30'h3DDD_EEEE;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [7:0] upc, input logic [29:0] ctrl, input logic wt);
        exp_t e;
        e.upc = upc; e.ctrl = ctrl; e.wt = wt;
        sb.push_back(e);
    endtask

    task automatic writeWord(input logic sel, input logic [7:0] addr, input logic [31:0] data,
                             input logic expAck);
        wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
        tick();
        wr_en_i = 1'b0;
        checkOutput("wr_ack", {63'd0, wr_ack_o}, {63'd0, expAck});
    endtask

    task automatic applyStimulus(input logic [5:0] op);
        instr_valid_i = 1'b1;
        opcode_i = op;
        tick();
        instr_valid_i = 1'b0;
    endtask

    task automatic doRestart();
        restart_i = 1'b1;
        instr_valid_i = 1'b1;
        opcode_i = 6'h23;
        #1;
        checkOutput("ready_in_restart", {63'd0, instr_ready_o}, 64'd0);
        tick();
        restart_i = 1'b0;
        instr_valid_i = 1'b0;
        checkOutput("restart_fault", {63'd0, fault_o}, 64'd0);
        checkOutput("restart_halt", {63'd0, halted_o}, 64'd0);
        checkOutput("restart_cause", {62'd0, fault_cause_o}, 64'd0);
        checkOutput("restart_ready", {63'd0, instr_ready_o}, 64'd1);
    endtask

    // Monitor: every live word must match the head of the queue; pop when it advances.
    always @(negedge clk) begin
        if (rst_n && ctrl_valid_o) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_word", {34'd0, ctrl_o}, 64'd0);
            end else begin
                checkOutput("word_ctrl", {34'd0, ctrl_o}, {34'd0, sb[0].ctrl});
                checkOutput("word_upc", {56'd0, upc_o}, {56'd0, sb[0].upc});
                if (!stall_i && (!sb[0].wt || cond_i)) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1);
    end

    initial begin
        #12;
        checkOutput("reset_valid", {63'd0, ctrl_valid_o}, 64'd0);
        checkOutput("reset_ctrl", {34'd0, ctrl_o}, 64'd0);
        checkOutput("reset_upc", {56'd0, upc_o}, 64'd0);
        checkOutput("reset_status", {59'd0, halted_o, fault_o, fault_cause_o, wr_ack_o}, 64'd0);
        rst_n = 1'b1;
        tick();

        wr_en_i = 1'b1; instr_valid_i = 1'b1; opcode_i = 6'h23;
        #1;
        checkOutput("write_blocks_accept", {63'd0, instr_ready_o}, 64'd0);
        instr_valid_i = 1'b0;
        writeWord(1'b0, 8'h10, {A, 2'b00}, 1'b1);
        writeWord(1'b0, 8'h11, {B, 2'b01}, 1'b1);
        writeWord(1'b0, 8'h20, {C, 2'b01}, 1'b1);
        writeWord(1'b0, 8'h30, {D, 2'b00}, 1'b1);
        writeWord(1'b0, 8'h31, {E, 2'b10}, 1'b1);
        writeWord(1'b0, 8'h32, {F, 2'b01}, 1'b1);
        writeWord(1'b0, 8'hFF, {G, 2'b00}, 1'b1);
        writeWord(1'b1, 8'h23, 32'h10, 1'b1);
        writeWord(1'b1, 8'h24, 32'h20, 1'b1);
        writeWord(1'b1, 8'h25, 32'h30, 1'b1);
        writeWord(1'b1, 8'h26, 32'hFF, 1'b1);
        tick();
        checkOutput("idle_no_ack", {63'd0, wr_ack_o}, 64'd0);

        // Basic two-word segment
        pushWord(8'h10, A, 1'b0);
        pushWord(8'h11, B, 1'b0);
        applyStimulus(6'h23);
        checkOutput("latency_valid", {63'd0, ctrl_valid_o}, 64'd1);
        tick();
        checkOutput("second_word_valid", {63'd0, ctrl_valid_o}, 64'd1);
        tick();
        checkOutput("seg_end_valid", {63'd0, ctrl_valid_o}, 64'd0);
        checkOutput("seg_end_ctrl", {34'd0, ctrl_o}, 64'd0);
        checkOutput("seg_end_ready", {63'd0, instr_ready_o}, 64'd1);

        // Back-to-back dispatch with no bubble
        pushWord(8'h10, A, 1'b0);
        pushWord(8'h11, B, 1'b0);
        pushWord(8'h20, C, 1'b0);
        instr_valid_i = 1'b1; opcode_i = 6'h23;
        tick();
        opcode_i = 6'h24;
        tick();
        checkOutput("b2b_ready_on_eos", {63'd0, instr_ready_o}, 64'd1);
        tick();
        instr_valid_i = 1'b0;
        checkOutput("b2b_no_gap", {63'd0, ctrl_valid_o}, 64'd1);
        checkOutput("b2b_upc", {56'd0, upc_o}, 64'h20);
        tick();
        checkOutput("b2b_end", {63'd0, ctrl_valid_o}, 64'd0);

        // Stall for three cycles, then WAIT word held until cond_i
        pushWord(8'h30, D, 1'b0);
        pushWord(8'h31, E, 1'b1);
        pushWord(8'h32, F, 1'b0);
        applyStimulus(6'h25);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_hold_upc", {56'd0, upc_o}, 64'h30);
            tick();
        end
        stall_i = 1'b0;
        checkOutput("stall_fourth_upc", {56'd0, upc_o}, 64'h30);
        tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput("wait_hold_upc", {56'd0, upc_o}, 64'h31);
            tick();
        end
        stall_i = 1'b1; cond_i = 1'b1;
        tick();
        checkOutput("stall_over_cond", {56'd0, upc_o}, 64'h31);
        stall_i = 1'b0;
        tick();
        cond_i = 1'b0;
        checkOutput("wait_release", {56'd0, upc_o}, 64'h32);
        tick();
        checkOutput("stall_seg_end", {63'd0, ctrl_valid_o}, 64'd0);

        // Undefined opcode and store overrun
        applyStimulus(6'h05);
        checkOutput("undef_fault", {63'd0, fault_o}, 64'd1);
        checkOutput("undef_cause", {62'd0, fault_cause_o}, 64'd1);
        checkOutput("undef_valid", {63'd0, ctrl_valid_o}, 64'd0);
        doRestart();
        pushWord(8'hFF, G, 1'b0);
        applyStimulus(6'h26);
        tick();
        checkOutput("overrun_fault", {63'd0, fault_o}, 64'd1);
        checkOutput("overrun_cause", {62'd0, fault_cause_o}, 64'd2);
        checkOutput("overrun_upc", {56'd0, upc_o}, 64'd0);
        doRestart();

        // Halt, writes while halted, then a write attempted during RUN
        applyStimulus(6'h3F);
        checkOutput("halt_flag", {63'd0, halted_o}, 64'd1);
        checkOutput("halt_ctrl", {34'd0, ctrl_o}, 64'd0);
        checkOutput("halt_valid", {63'd0, ctrl_valid_o}, 64'd0);
        writeWord(1'b0, 8'h40, {H, 2'b01}, 1'b1);
        writeWord(1'b1, 8'h27, 32'h40, 1'b1);
        doRestart();
        pushWord(8'h10, A, 1'b0);
        pushWord(8'h11, B, 1'b0);
        applyStimulus(6'h23);
        writeWord(1'b0, 8'h40, {X, 2'b01}, 1'b0);
        tick();
        pushWord(8'h40, H, 1'b0);
        applyStimulus(6'h27);
        tick();
        checkOutput("run_write_end", {63'd0, ctrl_valid_o}, 64'd0);

        // Reset mid-segment clears outputs and dispatch valid bits
        pushWord(8'h30, D, 1'b0);
        applyStimulus(6'h25);
        stall_i = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("rst_mid_valid", {63'd0, ctrl_valid_o}, 64'd0);
        checkOutput("rst_mid_ctrl", {34'd0, ctrl_o}, 64'd0);
        checkOutput("rst_mid_upc", {56'd0, upc_o}, 64'd0);
        stall_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(6'h23);
        checkOutput("post_rst_fault", {63'd0, fault_o}, 64'd1);
        checkOutput("post_rst_cause", {62'd0, fault_cause_o}, 64'd1);
        doRestart();

        tick();
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/microcode_seq.md
Name: microcode_seq

Overview:
- Parametrised microcode sequencer; next generation of the CPU's microcode control unit.
- Holds a writable control store and a writable opcode dispatch table.
- Accepts opcodes through a valid/ready handshake and streams control words to the datapath, with stall, wait-on-condition, back-to-back dispatch, halt and fault handling.
- Sits between instruction decode and the datapath control inputs.

Parameters:
CTRL_WIDTH, 32, stored word width; bit0 = EOS (end of segment), bit1 = WAIT, bits [CTRL_WIDTH-1:2] = datapath controls
ADDR_WIDTH, 8, control store address width; depth = 2^ADDR_WIDTH
OPCODE_WIDTH, 6, opcode width; dispatch table has 2^OPCODE_WIDTH entries
HALT_OPCODE, all ones (OPCODE_WIDTH bits), opcode that halts the unit

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
instr_valid_i  in  1  opcode offered
instr_ready_o  out  1  sequencer accepts opcode this cycle
opcode_i  in  OPCODE_WIDTH  opcode to dispatch
ctrl_o  out  CTRL_WIDTH-2  datapath control bits of the current word
ctrl_valid_o  out  1  ctrl_o is live
stall_i  in  1  datapath holds the current word
cond_i  in  1  condition that releases a WAIT word
restart_i  in  1  leave HALT/FAULT
halted_o  out  1  in HALT
fault_o  out  1  in FAULT
fault_cause_o  out  2  0 none, 1 undefined opcode, 2 store overrun
upc_o  out  ADDR_WIDTH  address of the word on ctrl_o (debug)
wr_en_i  in  1  programming write request
wr_sel_i  in  1  0 = control store, 1 = dispatch table
wr_addr_i  in  ADDR_WIDTH  store address, or opcode in the low OPCODE_WIDTH bits
wr_data_i  in  CTRL_WIDTH  store word, or entry address in the low ADDR_WIDTH bits
wr_ack_o  out  1  one-cycle pulse: write performed

Behaviour:
- States: IDLE, RUN, HALT, FAULT. Reset (async, any time, including mid-segment) forces:
  - state IDLE, ctrl_o = 0, ctrl_valid_o = 0, upc_o = 0, halted_o = 0, fault_o = 0, fault_cause_o = 0, wr_ack_o = 0.
  - All dispatch valid bits cleared; store contents not reset.
- Writes:
  - Performed only in IDLE, HALT or FAULT; wr_ack_o pulses the next cycle.
  - A dispatch write sets that entry's valid bit.
  - In RUN, wr_en_i is ignored and no ack is given.
- instr_ready_o = (IDLE and not wr_en_i), or (RUN and current word has EOS and advance). Accept = instr_valid_i and instr_ready_o.
- advance = ctrl_valid_o and not stall_i and (not WAIT or cond_i).
- Accept with opcode == HALT_OPCODE: next cycle HALT, halted_o = 1, ctrl_valid_o = 0, ctrl_o = 0.
- Accept with the dispatch entry invalid: next cycle FAULT, fault_cause_o = 1, ctrl_valid_o = 0.
- Accept with a valid entry E:
  - Next cycle RUN, ctrl_o = store[E] control bits, upc_o = E, ctrl_valid_o = 1.
  - Latency is 1 cycle from accept to first word.
- RUN, no advance: ctrl_o and upc_o held, ctrl_valid_o stays 1.
- RUN, advance on a non-EOS word:
  - upc + 1 is loaded next cycle.
  - If upc = 2^ADDR_WIDTH-1, go to FAULT with fault_cause_o = 2 instead; no wrap.
- RUN, advance on an EOS word:
  - With accept in the same cycle: dispatch as above, so back-to-back segments have no bubble.
  - Without accept: IDLE, ctrl_valid_o = 0, ctrl_o = 0.
- HALT/FAULT: outputs frozen at zero. restart_i goes to IDLE next cycle and clears halted_o, fault_o and fault_cause_o. No opcode is accepted in the restart cycle.
- Priorities:
  - Reset over everything.
  - A write in IDLE blocks accept that cycle.
  - stall_i overrides cond_i.

Test Plan:
- Program store[0x10] = {ctrl=A,0,0} and store[0x11] = {ctrl=B,0,EOS}; dispatch[0x23] = 0x10; offer 0x23 at cycle N -> ctrl_o = A at N+1, B at N+2, ctrl_valid_o low at N+3, instr_ready_o high.
- Two opcodes back-to-back (instr_valid_i held) -> second segment's first word appears the cycle after the first segment's EOS word; no gap in ctrl_valid_o.
- stall_i high 3 cycles on word A, then a WAIT word with cond_i low 2 cycles -> A held 4 cycles, WAIT word held until cond_i = 1, upc_o unchanged while held.
- Offer an unprogrammed opcode 0x05 -> fault_o = 1, fault_cause_o = 1; restart_i -> IDLE next cycle. A segment starting at 0xFF with no EOS -> fault_cause_o = 2 on advance.
- Offer HALT_OPCODE 0x3F -> halted_o = 1, ctrl_o = 0. Write in HALT -> wr_ack_o pulse. Write attempted during RUN -> no ack, store unchanged.
- Assert rst_n = 0 mid-segment -> outputs zero immediately. After release, a previously programmed opcode faults with cause 1, because dispatch valid bits were cleared.
